// File: rtl/a78_cart_loader.sv
// A78 cartridge loader: strips/decodes the 128-byte A78 header and streams the ROM payload to SDRAM.
// Optional A78_SIZE_CHECK_EN: flags a header-declared size that disagrees with the bytes actually loaded.
module a78_cart_loader #(
    parameter int unsigned ADDR_W    = 25,
    parameter int unsigned HDR_LEN   = 128,
    parameter int unsigned MAGIC_LEN = 9
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic              ioctl_wait,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              mem_wr,
    input  logic              mem_ack,
    output logic [15:0]       cart_flags,
    output logic [31:0]       cart_size,
    output logic [7:0]        cart_save,
    output logic [7:0]        cart_xm,
    output logic              cart_pal,
    output logic              header_found,
    output logic              load_done,
    output logic              size_mismatch
);

    localparam int unsigned CNT_W   = $clog2(HDR_LEN) + 1;
    localparam int unsigned BUF_LEN = MAGIC_LEN + 1;
    localparam int unsigned BI_W    = $clog2(BUF_LEN) + 1;
    localparam logic [8*MAGIC_LEN-1:0] MAGIC = 72'h41_54_41_52_49_37_38_30_30;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_HEADER,
        S_FLUSH,
        S_STREAM,
        S_DONE
    } state_t;

    state_t              r_state;
    logic                r_dl_d;
    logic [CNT_W-1:0]    r_cnt;
    logic [7:0]          r_buf [0:BUF_LEN-1];
    logic [BI_W-1:0]     r_fidx;
    logic [BI_W-1:0]     r_fn;
    logic [ADDR_W-1:0]   r_paddr;
    logic                r_full;
    logic [31:0]         r_wcount;
    logic                r_wait;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [7:0]          r_mem_data;
    logic                r_mem_wr;
    logic [15:0]         r_flags;
    logic [31:0]         r_size;
    logic [7:0]          r_save;
    logic [7:0]          r_xm;
    logic                r_pal;
    logic                r_hfound;
    logic                r_done;
    logic [8*MAGIC_LEN-1:0] w_sig;
    logic                w_unused;
`ifdef A78_SIZE_CHECK_EN
    logic [31:0]         r_hdr_size;
    logic                r_mismatch;
`endif

    assign w_unused = ^ioctl_addr;

    // Signature as it stands once the last magic byte arrives: buffered bytes plus the live one.
    always_comb begin
        w_sig = '0;
        for (int unsigned i = 1; i < MAGIC_LEN; i++) begin
            w_sig[8*(MAGIC_LEN-i) +: 8] = r_buf[i];
        end
        w_sig[7:0] = ioctl_dout;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_dl_d     <= 1'b1;  // a download still high after reset is not a new start
            r_cnt      <= '0;
            for (int unsigned i = 0; i < BUF_LEN; i++) r_buf[i] <= '0;
            r_fidx     <= '0;
            r_fn       <= '0;
            r_paddr    <= '0;
            r_full     <= 1'b0;
            r_wcount   <= '0;
            r_wait     <= 1'b0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
            r_mem_wr   <= 1'b0;
            r_flags    <= '0;
            r_size     <= '0;
            r_save     <= '0;
            r_xm       <= '0;
            r_pal      <= 1'b0;
            r_hfound   <= 1'b0;
            r_done     <= 1'b0;
`ifdef A78_SIZE_CHECK_EN
            r_hdr_size <= '0;
            r_mismatch <= 1'b0;
`endif
        end else begin
            r_dl_d <= ioctl_download;
            if (ioctl_download && !r_dl_d) begin
                r_state    <= S_CAPTURE;
                r_cnt      <= '0;
                r_fidx     <= '0;
                r_fn       <= '0;
                r_paddr    <= '0;
                r_full     <= 1'b0;
                r_wcount   <= '0;
                r_wait     <= 1'b0;
                r_mem_wr   <= 1'b0;
                r_flags    <= '0;
                r_size     <= '0;
                r_save     <= '0;
                r_xm       <= '0;
                r_pal      <= 1'b0;
                r_hfound   <= 1'b0;
                r_done     <= 1'b0;
`ifdef A78_SIZE_CHECK_EN
                r_hdr_size <= '0;
                r_mismatch <= 1'b0;
`endif
            end else begin
                unique case (r_state)
                    S_CAPTURE: begin
                        if (ioctl_wr) begin
                            r_buf[r_cnt[BI_W-1:0]] <= ioctl_dout;
                            r_cnt <= r_cnt + 1'b1;
                            if (r_cnt == CNT_W'(MAGIC_LEN)) begin
                                if (w_sig == MAGIC) begin
                                    r_hfound <= 1'b1;
                                    r_state  <= S_HEADER;
                                end else begin
                                    r_fn    <= BI_W'(BUF_LEN);
                                    r_fidx  <= '0;
                                    r_wait  <= 1'b1;
                                    r_state <= S_FLUSH;
                                end
                            end
                        end else if (!ioctl_download) begin
                            r_fn    <= r_cnt[BI_W-1:0];
                            r_fidx  <= '0;
                            r_wait  <= 1'b1;
                            r_state <= S_FLUSH;
                        end
                    end
                    S_HEADER: begin
                        if (ioctl_wr) begin
                            r_cnt <= r_cnt + 1'b1;
                            if (r_cnt == CNT_W'(53)) r_flags[15:8] <= ioctl_dout;
                            if (r_cnt == CNT_W'(54)) r_flags[7:0]  <= ioctl_dout;
                            if (r_cnt == CNT_W'(57)) r_pal         <= ioctl_dout[0];
                            if (r_cnt == CNT_W'(58)) r_save        <= ioctl_dout;
                            if (r_cnt == CNT_W'(63)) r_xm          <= ioctl_dout;
`ifdef A78_SIZE_CHECK_EN
                            if (r_cnt >= CNT_W'(49) && r_cnt <= CNT_W'(52))
                                r_hdr_size <= {r_hdr_size[23:0], ioctl_dout};
`endif
                            if (r_cnt == CNT_W'(HDR_LEN-1)) begin
                                r_paddr <= '0;
                                r_state <= S_STREAM;
                            end
                        end else if (!ioctl_download) begin
                            r_size  <= r_wcount;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
`ifdef A78_SIZE_CHECK_EN
                            r_mismatch <= r_hfound && (r_hdr_size != r_wcount);
`endif
                        end
                    end
                    S_FLUSH: begin
                        if (r_mem_wr) begin
                            if (mem_ack) begin
                                r_mem_wr <= 1'b0;
                                r_fidx   <= r_fidx + 1'b1;
                                r_paddr  <= r_paddr + 1'b1;
                                r_wcount <= r_wcount + 1'b1;
                            end
                        end else if (r_fidx < r_fn) begin
                            r_mem_addr <= ADDR_W'(r_fidx);
                            r_mem_data <= r_buf[r_fidx];
                            r_mem_wr   <= 1'b1;
                        end else begin
                            r_wait  <= 1'b0;
                            r_state <= S_STREAM;
                        end
                    end
                    S_STREAM: begin
                        if (r_mem_wr) begin
                            if (mem_ack) begin
                                r_mem_wr <= 1'b0;
                                r_wait   <= 1'b0;
                                if (r_paddr == '1) r_full  <= 1'b1;
                                else               r_paddr <= r_paddr + 1'b1;
                            end
                        end else if (ioctl_wr) begin
                            // Bytes past the top address are counted but never written.
                            r_wcount <= r_wcount + 1'b1;
                            if (!r_full) begin
                                r_mem_addr <= r_paddr;
                                r_mem_data <= ioctl_dout;
                                r_mem_wr   <= 1'b1;
                                r_wait     <= 1'b1;
                            end
                        end else if (!ioctl_download) begin
                            r_size  <= r_wcount;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
`ifdef A78_SIZE_CHECK_EN
                            r_mismatch <= r_hfound && (r_hdr_size != r_wcount);
`endif
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign ioctl_wait   = r_wait;
    assign mem_addr     = r_mem_addr;
    assign mem_data     = r_mem_data;
    assign mem_wr       = r_mem_wr;
    assign cart_flags   = r_flags;
    assign cart_size    = r_size;
    assign cart_save    = r_save;
    assign cart_xm      = r_xm;
    assign cart_pal     = r_pal;
    assign header_found = r_hfound;
    assign load_done    = r_done;
`ifdef A78_SIZE_CHECK_EN
    assign size_mismatch = r_mismatch;
`else
    assign size_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_a78_cart_loader.sv
// Scoreboarded bench for a78_cart_loader (ADDR_W reduced to 12 so address saturation is reachable).
module tb_a78_cart_loader;

    localparam int unsigned AW = 12;

    logic          clk_sys = 1'b0;
    logic          reset = 1'b1;
    logic          ioctl_download = 1'b0;
    logic          ioctl_wr = 1'b0;
    logic [24:0]   ioctl_addr = '0;
    logic [7:0]    ioctl_dout = '0;
    logic          ioctl_wait;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_data;
    logic          mem_wr;
    logic          mem_ack = 1'b0;
    logic [15:0]   cart_flags;
    logic [31:0]   cart_size;
    logic [7:0]    cart_save;
    logic [7:0]    cart_xm;
    logic          cart_pal;
    logic          header_found;
    logic          load_done;
    logic          size_mismatch;

    a78_cart_loader #(.ADDR_W(AW), .HDR_LEN(128), .MAGIC_LEN(9)) dut (
        .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ioctl_wait(ioctl_wait), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_wr(mem_wr), .mem_ack(mem_ack), .cart_flags(cart_flags),
        .cart_size(cart_size), .cart_save(cart_save), .cart_xm(cart_xm),
        .cart_pal(cart_pal), .header_found(header_found), .load_done(load_done),
        .size_mismatch(size_mismatch)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    wr_t         exp_q[$];
    int unsigned n_total = 0;
    int unsigned n_bad = 0;
    int unsigned ack_delay = 0;
    int unsigned hold_err = 0;
    int unsigned drop_err = 0;
    logic        skip_drop = 1'b0;
    logic [71:0] magic = "ATARI7800";

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // SDRAM responder: acks after ack_delay extra cycles and pops the scoreboard on each write.
    initial begin : ack_proc
        int unsigned dly = 0;
        logic        prev_wr = 1'b0;
        wr_t         e;
        forever begin
            @(posedge clk_sys); #1;
            if (prev_wr && !mem_wr && !mem_ack && !skip_drop) drop_err++;
            prev_wr = mem_wr;
            if (mem_ack) begin
                mem_ack = 1'b0;
            end else if (mem_wr) begin
                if (ioctl_wait !== 1'b1) hold_err++;
                if (dly >= ack_delay) begin
                    dly = 0;
                    mem_ack = 1'b1;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_wr", 32'(mem_addr), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wr_addr", 32'(mem_addr), 32'(e.addr));
                        chk("wr_data", 32'(mem_data), 32'(e.data));
                    end
                end else begin
                    dly++;
                end
            end else begin
                dly = 0;
            end
        end
    end

    initial begin : watchdog
        #(95000 * 10);
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [7:0] pay_b(input int i);
        return 8'(i * 7 + (i >> 8) + 3);
    endfunction

    function automatic logic [7:0] raw_b(input int i);
        if (i == 0) return 8'hAA;
        if (i == 1) return 8'h55;
        return 8'(i * 13 + 5);
    endfunction

    task automatic clks(input int n);
        for (int k = 0; k < n; k++) begin @(posedge clk_sys); #1; end
    endtask

    task automatic start_dl();
        ioctl_download = 1'b1;
        @(posedge clk_sys); #1;
        chk("start_done", 32'(load_done), 0);
        chk("start_hfound", 32'(header_found), 0);
    endtask

    task automatic send(input logic [7:0] b, input logic push, input logic [AW-1:0] a);
        int t = 0;
        wr_t e;
        while (ioctl_wait && t < 2000) begin @(posedge clk_sys); #1; t++; end
        if (t >= 2000) chk("wait_timeout", 32'(ioctl_wait), 0);
        if (push) begin
            e.addr = a;
            e.data = b;
            exp_q.push_back(e);
        end
        ioctl_wr = 1'b1;
        ioctl_dout = b;
        @(posedge clk_sys); #1;
        ioctl_wr = 1'b0;
    endtask

    task automatic finish_dl();
        int t = 0;
        ioctl_download = 1'b0;
        while (!load_done && t < 20000) begin @(posedge clk_sys); #1; t++; end
        if (!load_done) chk("done_timeout", 32'(load_done), 1);
        chk("q_left", exp_q.size(), 0);
    endtask

    task automatic chk_cfg(input logic hf, input logic [15:0] fl, input logic pal,
                           input logic [7:0] sv, input logic [7:0] xm,
                           input logic [31:0] sz, input logic mm);
        chk("load_done", 32'(load_done), 1);
        chk("header_found", 32'(header_found), 32'(hf));
        chk("cart_flags", 32'(cart_flags), 32'(fl));
        chk("cart_pal", 32'(cart_pal), 32'(pal));
        chk("cart_save", 32'(cart_save), 32'(sv));
        chk("cart_xm", 32'(cart_xm), 32'(xm));
        chk("cart_size", cart_size, sz);
        chk("size_mismatch", 32'(size_mismatch), 32'(mm));
        chk("mem_wr_idle", 32'(mem_wr), 0);
    endtask

    task automatic send_hdr(input logic [15:0] fl, input logic pal, input logic [7:0] sv,
                            input logic [7:0] xm, input logic [31:0] hsz);
        logic [7:0] b;
        for (int i = 0; i < 128; i++) begin
            b = 8'h00;
            if (i == 0) b = 8'h03;
            else if (i <= 9) b = magic[8*(9-i) +: 8];
            else if (i == 49) b = hsz[31:24];
            else if (i == 50) b = hsz[23:16];
            else if (i == 51) b = hsz[15:8];
            else if (i == 52) b = hsz[7:0];
            else if (i == 53) b = fl[15:8];
            else if (i == 54) b = fl[7:0];
            else if (i == 57) b = {7'h11, pal};
            else if (i == 58) b = sv;
            else if (i == 63) b = xm;
            else if (i > 63) b = 8'(i);
            send(b, 1'b0, '0);
        end
    endtask

    task automatic load_hdr(input int n, input logic [15:0] fl, input logic pal,
                            input logic [7:0] sv, input logic [7:0] xm, input logic [31:0] hsz);
        start_dl();
        send_hdr(fl, pal, sv, xm, hsz);
        chk("hfound_early", 32'(header_found), 1);
        for (int i = 0; i < n; i++) send(pay_b(i), 1'b1, AW'(i));
        finish_dl();
    endtask

    task automatic load_raw(input int n);
        start_dl();
        for (int i = 0; i < n; i++) begin
            send(raw_b(i), (i < (1 << AW)), AW'(i));
            if (i == 9) chk("flush_wait", 32'(ioctl_wait), 1);
        end
        finish_dl();
    endtask

    initial begin : main
        logic mm_exp;
        clks(4);
        chk("rst_wait", 32'(ioctl_wait), 0);
        chk("rst_mem_wr", 32'(mem_wr), 0);
        chk("rst_done", 32'(load_done), 0);
        chk("rst_size", cart_size, 0);
        chk("rst_flags", 32'(cart_flags), 0);
        reset = 1'b0;
        clks(2);

        // Header image with 1024 payload bytes, matching size field.
        load_hdr(1024, 16'h0002, 1'b0, 8'h02, 8'h01, 32'd1024);
        chk_cfg(1'b1, 16'h0002, 1'b0, 8'h02, 8'h01, 32'd1024, 1'b0);

        // Headerless image: first ten bytes go out through the flush path.
        load_raw(2048);
        chk_cfg(1'b0, 16'h0000, 1'b0, 8'h00, 8'h00, 32'd2048, 1'b0);

        // Slow SDRAM.
        ack_delay = 7;
        load_hdr(64, 16'h8F10, 1'b1, 8'h01, 8'h03, 32'd64);
        chk_cfg(1'b1, 16'h8F10, 1'b1, 8'h01, 8'h03, 32'd64, 1'b0);
        ack_delay = 0;

        // File shorter than the signature window.
        load_raw(5);
        chk_cfg(1'b0, 16'h0000, 1'b0, 8'h00, 8'h00, 32'd5, 1'b0);

        // Reset while payload byte 100 is pending in SDRAM.
        ack_delay = 3;
        start_dl();
        send_hdr(16'h0002, 1'b0, 8'h02, 8'h01, 32'd200);
        for (int i = 0; i <= 100; i++) send(pay_b(i), 1'b1, AW'(i));
        chk("pend_mem_wr", 32'(mem_wr), 1);
        skip_drop = 1'b1;
        reset = 1'b1;
        @(posedge clk_sys); #1;
        reset = 1'b0;
        exp_q.delete();
        chk("abort_mem_wr", 32'(mem_wr), 0);
        chk("abort_wait", 32'(ioctl_wait), 0);
        chk("abort_hfound", 32'(header_found), 0);
        chk("abort_flags", 32'(cart_flags), 0);
        for (int i = 101; i < 121; i++) send(pay_b(i), 1'b0, '0);
        clks(10);
        ioctl_download = 1'b0;
        clks(10);
        chk("abort_done", 32'(load_done), 0);
        chk("abort_size", cart_size, 0);
        chk("abort_hfound2", 32'(header_found), 0);
        skip_drop = 1'b0;
        ack_delay = 0;
        load_hdr(300, 16'h0102, 1'b0, 8'h00, 8'h02, 32'd300);
        chk_cfg(1'b1, 16'h0102, 1'b0, 8'h00, 8'h02, 32'd300, 1'b0);

        // Header size field disagreeing with the payload length.
`ifdef A78_SIZE_CHECK_EN
        mm_exp = 1'b1;
`else
        mm_exp = 1'b0;
`endif
        load_hdr(192, 16'h0000, 1'b0, 8'h00, 8'h00, 32'h0000_0100);
        chk_cfg(1'b1, 16'h0000, 1'b0, 8'h00, 8'h00, 32'd192, mm_exp);
        load_hdr(192, 16'h0000, 1'b0, 8'h00, 8'h00, 32'd192);
        chk_cfg(1'b1, 16'h0000, 1'b0, 8'h00, 8'h00, 32'd192, 1'b0);

        // Payload running past the top address: extra bytes counted, not written.
        load_raw((1 << AW) + 4);
        chk_cfg(1'b0, 16'h0000, 1'b0, 8'h00, 8'h00, 32'((1 << AW) + 4), 1'b0);

        chk("wait_hold", hold_err, 0);
        chk("wr_drop", drop_err, 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/a78_cart_loader.md
Name: a78_cart_loader

Overview:
- Receives a cartridge image byte stream from the HPS download channel and writes the ROM payload into cart SDRAM.
- Detects and strips the 128-byte A78 header, and decodes it into the configuration words the cart mapper consumes: cart_flags, cart_size, cart_save, cart_xm, and the TV type.
- Sits between the ioctl download port and the SDRAM write port. Its outputs feed the cart mapper directly.

Parameters:
ADDR_W, 25, SDRAM byte address width
HDR_LEN, 128, A78 header length in bytes
MAGIC_LEN, 9, length of the "ATARI7800" signature at header bytes 1..9

Ports:
clk_sys  in  1  system clock
reset  in  1  synchronous, active-high reset
ioctl_download  in  1  high for the whole image transfer
ioctl_wr  in  1  one-cycle strobe; byte valid; never asserted while ioctl_wait=1
ioctl_addr  in  25  byte index within the file (informational only; the block keeps its own counter)
ioctl_dout  in  8  file byte
ioctl_wait  out  1  stalls the HPS while a write is pending or the buffer is flushing
mem_addr  out  ADDR_W  SDRAM byte address
mem_data  out  8  SDRAM write byte
mem_wr  out  1  write request; held until mem_ack
mem_ack  in  1  one-cycle acknowledge; write complete
cart_flags  out  16  header cart type word (byte53 = [15:8], byte54 = [7:0])
cart_size  out  32  ROM payload bytes written
cart_save  out  8  header byte 58
cart_xm  out  8  header byte 63
cart_pal  out  1  header byte 57 bit0
header_found  out  1  valid A78 signature detected
load_done  out  1  level; configuration outputs are valid
size_mismatch  out  1  see Optional Feature

Behaviour:
- Reset values: all outputs 0, state IDLE, byte counter 0.
- Reset mid-transfer aborts the load. Nothing further is written; the outputs stay 0 until the next ioctl_download rising edge.
- A rising edge of ioctl_download in any state does the following:
  - enter CAPTURE;
  - clear the counter, the config outputs, load_done and header_found.
- CAPTURE: each ioctl_wr stores the byte into a 10-entry buffer at the counter index, then the counter increments.
  - When byte index 9 is stored, compare buffer bytes 1..9 against "ATARI7800" (0x41 0x54 0x41 0x52 0x49 0x37 0x38 0x30 0x30).
  - Match: header_found<=1, go to HEADER.
  - No match: go to FLUSH, with ioctl_wait=1 from the following cycle.
- FLUSH: write buffer entries 0..N-1 to mem_addr 0..N-1, one mem_wr/mem_ack handshake each, then go to STREAM. ioctl_wait stays 1 throughout.
- HEADER: bytes with index 10..HDR_LEN-1 are consumed with no memory write.
  - Latch index 53, 54, 57, 58 and 63 into the matching outputs.
  - Latch index 49..52 as a big-endian 32-bit header size (hdr_size).
  - After index HDR_LEN-1, go to STREAM with the payload address at 0.
- STREAM: each ioctl_wr does the following:
  - set mem_addr = payload address, mem_data = byte, mem_wr=1 and ioctl_wait=1 in the next cycle;
  - on mem_ack: mem_wr<=0 and ioctl_wait<=0 in the same edge, payload address +1.
  - Write latency from ioctl_wr to mem_wr is 1 cycle.
- Falling edge of ioctl_download:
  - Any pending write completes first.
  - If still in CAPTURE (file shorter than 10 bytes), flush the buffer as headerless, then finish.
  - If in HEADER (truncated header), finish with cart_size=0.
  - Finish: cart_size <= payload bytes written, load_done<=1, state DONE.
- DONE holds all outputs until reset or the next download.
- A headerless load leaves cart_flags/save/xm/pal at 0.
- The payload address saturates at 2^ADDR_W-1. Writes beyond that are dropped, but cart_size still counts them.
- mem_wr never deasserts without mem_ack. ioctl_wait is high whenever mem_wr=1.

Optional Feature:
- Macro: A78_SIZE_CHECK_EN.
- Defined: at finish, if header_found and hdr_size != cart_size, then size_mismatch<=1. It clears with the other outputs.
- Undefined: size_mismatch is tied 0, and hdr_size is not stored.

Test Plan:
- 128-byte header with magic, byte53=0x00, byte54=0x02, byte58=0x02, byte63=0x01, followed by 0x20000 payload bytes -> header_found=1, cart_flags=0x0002, cart_save=0x02, cart_xm=0x01, cart_size=0x20000. Payload byte 0 lands at mem_addr 0; the last byte lands at 0x1FFFF.
- Headerless 0x8000-byte image starting 0xAA,0x55,... -> header_found=0, flags=0, cart_size=0x8000. Bytes 0..9 are written at addresses 0..9 during FLUSH, with ioctl_wait high.
- mem_ack delayed 7 cycles per write -> mem_wr and ioctl_wait held for 7 cycles, no byte lost, data at each address matches the file.
- 5-byte file -> all 5 bytes flushed to addresses 0..4, cart_size=5, load_done=1.
- Reset asserted at payload byte 100 -> mem_wr=0 the next cycle, outputs 0, no further writes. A new download then completes correctly.
- With A78_SIZE_CHECK_EN: header size field 0x00010000 with 0xC000 payload bytes -> size_mismatch=1. Matching sizes -> size_mismatch=0.
